// File: rtl/dma_burst_sched.sv
// RX DMA burst-slot scheduler: per-burst fill/skip decisions into a ring of host buffers,
// credit-based buffer ownership, toggle-coded statistics events and graceful stop with flush.
module dma_burst_sched #(
    parameter int unsigned MAX_BUSRTS_BITS = 5,
    parameter int unsigned RING_BITS       = 5,
    parameter int unsigned CNT_BITS        = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       dma_en,
    input  logic [MAX_BUSRTS_BITS-1:0] cfg_buff_brst_z,
    input  logic [RING_BITS-1:0]       cfg_ring_z,
    input  logic                       host_release_valid,
    input  logic [RING_BITS:0]         host_release_num,
    input  logic                       stop_req,
    input  logic                       brst_req_valid,
    output logic                       brst_req_ready,
    output logic                       grant_valid,
    output logic                       grant_fill,
    output logic [RING_BITS-1:0]       grant_buf_idx,
    output logic [MAX_BUSRTS_BITS-1:0] grant_brst_idx,
    output logic                       fifo_burst_fill,
    output logic                       fifo_burst_skip,
    output logic [RING_BITS:0]         credit,
    output logic [CNT_BITS-1:0]        ovr_cnt,
    output logic                       stop_done
);

    localparam int unsigned BW = MAX_BUSRTS_BITS;
    localparam int unsigned RW = RING_BITS;
    localparam int unsigned CW = RING_BITS + 1;
    localparam int unsigned SW = RING_BITS + 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          state, state_d;
    logic [BW-1:0]       cfg_brst_q, cfg_brst_d;
    logic [RW-1:0]       cfg_ring_q, cfg_ring_d;
    logic [RW-1:0]       wr_idx, wr_idx_d;
    logic [BW-1:0]       brst_idx, brst_idx_d;
    logic                owned_q, owned_d;
    logic [CW-1:0]       credit_d;
    logic [CNT_BITS-1:0] ovr_cnt_d;
    logic                grant_valid_d, grant_fill_d;
    logic [RW-1:0]       grant_buf_idx_d;
    logic [BW-1:0]       grant_brst_idx_d;
    logic                fill_tgl_d, skip_tgl_d, stop_done_d;

    logic                dec_en, dec_owned, wrap, consume, rel_en;
    logic [SW-1:0]       credit_sum, credit_cap;

    assign brst_req_ready = (state == S_RUN) & ~stop_req;

    // Next-state, decision and credit logic
    always_comb begin
        state_d          = state;
        cfg_brst_d       = cfg_brst_q;
        cfg_ring_d       = cfg_ring_q;
        wr_idx_d         = wr_idx;
        brst_idx_d       = brst_idx;
        owned_d          = owned_q;
        credit_d         = credit;
        ovr_cnt_d        = ovr_cnt;
        grant_valid_d    = 1'b0;
        grant_fill_d     = grant_fill;
        grant_buf_idx_d  = grant_buf_idx;
        grant_brst_idx_d = grant_brst_idx;
        fill_tgl_d       = fifo_burst_fill;
        skip_tgl_d       = fifo_burst_skip;
        dec_en           = 1'b0;
        dec_owned        = 1'b0;
        rel_en           = 1'b0;
        consume          = 1'b0;
        wrap             = (brst_idx == cfg_brst_q);
        credit_sum       = '0;
        credit_cap       = SW'(cfg_ring_q) + SW'(1);

        case (state)
            S_IDLE: begin
                if (dma_en) begin
                    state_d    = S_RUN;
                    cfg_brst_d = cfg_buff_brst_z;
                    cfg_ring_d = cfg_ring_z;
                    wr_idx_d   = '0;
                    brst_idx_d = '0;
                    owned_d    = 1'b0;
                    credit_d   = CW'(cfg_ring_z) + CW'(1);
                    ovr_cnt_d  = '0;
                end
            end
            S_RUN: begin
                rel_en = 1'b1;
                if (stop_req) begin
                    state_d = (brst_idx == '0) ? S_DONE : S_FLUSH;
                end else if (brst_req_valid) begin
                    dec_en    = 1'b1;
                    // Mode is fixed by the registered credit at the first slot of each buffer
                    dec_owned = (brst_idx == '0) ? (credit != '0) : owned_q;
                end
            end
            S_FLUSH: begin
                rel_en    = 1'b1;
                dec_en    = 1'b1;
                dec_owned = owned_q;
                if (wrap) begin
                    state_d = S_DONE;
                end
            end
            default: ;
        endcase

        if (!dma_en) begin
            state_d = S_IDLE;
            dec_en  = 1'b0;
            rel_en  = 1'b0;
        end

        if (dec_en) begin
            grant_valid_d    = 1'b1;
            grant_fill_d     = dec_owned & (state == S_RUN);
            grant_buf_idx_d  = wr_idx;
            grant_brst_idx_d = brst_idx;
            if (dec_owned && (state == S_RUN)) begin
                fill_tgl_d = ~fifo_burst_fill;
            end else begin
                skip_tgl_d = ~fifo_burst_skip;
            end
            owned_d = dec_owned;
            if (wrap) begin
                brst_idx_d = '0;
                if (dec_owned) begin
                    wr_idx_d = (wr_idx == cfg_ring_q) ? '0 : RW'(wr_idx + RW'(1));
                    consume  = (credit != '0);
                end else if (ovr_cnt != '1) begin
                    ovr_cnt_d = ovr_cnt + CNT_BITS'(1);
                end
            end else begin
                brst_idx_d = brst_idx + BW'(1);
            end
        end

        // Release and consume land together; ownership never exceeds the ring size
        if (rel_en) begin
            credit_sum = SW'(credit)
                       + (host_release_valid ? SW'(host_release_num) : SW'(0))
                       - SW'(consume);
            credit_d   = (credit_sum > credit_cap) ? CW'(credit_cap) : CW'(credit_sum);
        end

        stop_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            cfg_brst_q      <= '0;
            cfg_ring_q      <= '0;
            wr_idx          <= '0;
            brst_idx        <= '0;
            owned_q         <= 1'b0;
            credit          <= '0;
            ovr_cnt         <= '0;
            grant_valid     <= 1'b0;
            grant_fill      <= 1'b0;
            grant_buf_idx   <= '0;
            grant_brst_idx  <= '0;
            fifo_burst_fill <= 1'b0;
            fifo_burst_skip <= 1'b0;
            stop_done       <= 1'b0;
        end else begin
            state           <= state_d;
            cfg_brst_q      <= cfg_brst_d;
            cfg_ring_q      <= cfg_ring_d;
            wr_idx          <= wr_idx_d;
            brst_idx        <= brst_idx_d;
            owned_q         <= owned_d;
            credit          <= credit_d;
            ovr_cnt         <= ovr_cnt_d;
            grant_valid     <= grant_valid_d;
            grant_fill      <= grant_fill_d;
            grant_buf_idx   <= grant_buf_idx_d;
            grant_brst_idx  <= grant_brst_idx_d;
            fifo_burst_fill <= fill_tgl_d;
            fifo_burst_skip <= skip_tgl_d;
            stop_done       <= stop_done_d;
        end
    end

endmodule

// File: tb/tb_dma_burst_sched.sv
// Scoreboard bench for dma_burst_sched: expected decisions are queued at drive time
// and matched against grant pulses and event toggles sampled on the falling edge.
module tb_dma_burst_sched;

    localparam int unsigned BB = 5;
    localparam int unsigned RB = 5;
    localparam int unsigned CB = 16;

    typedef struct packed {
        logic          fill;
        logic [RB-1:0] buf_idx;
        logic [BB-1:0] brst;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dma_en;
    logic [BB-1:0] cfg_buff_brst_z;
    logic [RB-1:0] cfg_ring_z;
    logic          host_release_valid;
    logic [RB:0]   host_release_num;
    logic          stop_req;
    logic          brst_req_valid;
    logic          brst_req_ready;
    logic          grant_valid;
    logic          grant_fill;
    logic [RB-1:0] grant_buf_idx;
    logic [BB-1:0] grant_brst_idx;
    logic          fifo_burst_fill;
    logic          fifo_burst_skip;
    logic [RB:0]   credit;
    logic [CB-1:0] ovr_cnt;
    logic          stop_done;

    dma_burst_sched #(.MAX_BUSRTS_BITS(BB), .RING_BITS(RB), .CNT_BITS(CB)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .dma_en             (dma_en),
        .cfg_buff_brst_z    (cfg_buff_brst_z),
        .cfg_ring_z         (cfg_ring_z),
        .host_release_valid (host_release_valid),
        .host_release_num   (host_release_num),
        .stop_req           (stop_req),
        .brst_req_valid     (brst_req_valid),
        .brst_req_ready     (brst_req_ready),
        .grant_valid        (grant_valid),
        .grant_fill         (grant_fill),
        .grant_buf_idx      (grant_buf_idx),
        .grant_brst_idx     (grant_brst_idx),
        .fifo_burst_fill    (fifo_burst_fill),
        .fifo_burst_skip    (fifo_burst_skip),
        .credit             (credit),
        .ovr_cnt            (ovr_cnt),
        .stop_done          (stop_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t sb[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Decision monitor
    logic prev_f = 1'b0;
    logic prev_s = 1'b0;
    int   n_fill = 0;
    int   n_skip = 0;
    logic df, ds;
    exp_t e;

    always @(negedge clk) begin
        df     = fifo_burst_fill ^ prev_f;
        ds     = fifo_burst_skip ^ prev_s;
        prev_f = fifo_burst_fill;
        prev_s = fifo_burst_skip;
        if (df) n_fill++;
        if (ds) n_skip++;
        if (grant_valid) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_grant", 32'(grant_brst_idx) + 32'd100, 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("grant_fill", 32'(grant_fill), 32'(e.fill));
                check_eq("grant_buf_idx", 32'(grant_buf_idx), 32'(e.buf_idx));
                check_eq("grant_brst_idx", 32'(grant_brst_idx), 32'(e.brst));
                check_eq("fill_toggle", 32'(df), 32'(e.fill));
                check_eq("skip_toggle", 32'(ds), 32'(!e.fill));
            end
        end else begin
            check_eq("no_toggle", 32'({df, ds}), 32'd0);
        end
    end

    // Reference model of buffer ownership
    int m_credit, m_wr, m_bi, m_ring, m_bz, m_ovr;
    bit m_owned;

    task automatic model_start(input int ring_z, input int bz);
        m_ring   = ring_z;
        m_bz     = bz;
        m_credit = ring_z + 1;
        m_wr     = 0;
        m_bi     = 0;
        m_ovr    = 0;
        m_owned  = 1'b0;
    endtask

    task automatic push_exp(input bit fill, input int buf_i, input int brst_i);
        exp_t x;
        x.fill    = fill;
        x.buf_idx = RB'(buf_i);
        x.brst    = BB'(brst_i);
        sb.push_back(x);
    endtask

    // One cycle in RUN: optional request and release
    task automatic step(input bit v, input bit rel, input int num);
        bit own;
        int cons;
        cons               = 0;
        brst_req_valid     = v;
        host_release_valid = rel;
        host_release_num   = (RB+1)'(num);
        if (v) begin
            own = (m_bi == 0) ? (m_credit != 0) : m_owned;
            push_exp(own, m_wr, m_bi);
            m_owned = own;
            if (m_bi == m_bz) begin
                m_bi = 0;
                if (own) begin
                    m_wr = (m_wr + 1) % (m_ring + 1);
                    cons = 1;
                end else begin
                    m_ovr++;
                end
            end else begin
                m_bi++;
            end
        end
        m_credit = m_credit + (rel ? num : 0) - cons;
        if (m_credit > m_ring + 1) m_credit = m_ring + 1;
        @(posedge clk);
        #1;
        brst_req_valid     = 1'b0;
        host_release_valid = 1'b0;
        host_release_num   = '0;
    endtask

    initial begin
        rst_n              = 1'b0;
        dma_en             = 1'b0;
        cfg_buff_brst_z    = '0;
        cfg_ring_z         = '0;
        host_release_valid = 1'b0;
        host_release_num   = '0;
        stop_req           = 1'b0;
        brst_req_valid     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_grant_valid", 32'(grant_valid), 32'd0);
        check_eq("rst_fill", 32'(fifo_burst_fill), 32'd0);
        check_eq("rst_skip", 32'(fifo_burst_skip), 32'd0);
        check_eq("rst_credit", 32'(credit), 32'd0);
        check_eq("rst_ovr_cnt", 32'(ovr_cnt), 32'd0);
        check_eq("rst_stop_done", 32'(stop_done), 32'd0);
        check_eq("rst_ready", 32'(brst_req_ready), 32'd0);

        rst_n           = 1'b1;
        cfg_ring_z      = 5'd3;
        cfg_buff_brst_z = 5'd3;
        dma_en          = 1'b1;
        @(posedge clk);
        #1;
        model_start(3, 3);
        check_eq("start_credit", 32'(credit), 32'd4);
        check_eq("start_ready", 32'(brst_req_ready), 32'd1);

        // Fill the whole ring
        repeat (16) step(1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        check_eq("ring_credit", 32'(credit), 32'd0);
        check_eq("ring_fills", 32'(n_fill), 32'd16);
        check_eq("ring_skips", 32'(n_skip), 32'd0);
        check_eq("ring_ovr", 32'(ovr_cnt), 32'd0);

        // Two overrun buffers
        repeat (8) step(1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        check_eq("ovr_skips", 32'(n_skip), 32'd8);
        check_eq("ovr_cnt2", 32'(ovr_cnt), 32'd2);
        check_eq("ovr_credit", 32'(credit), 32'd0);

        // Release mid-OVR buffer does not rescue it; next buffer owned
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 1);
        step(1'b1, 1'b0, 0);
        check_eq("midrel_credit", 32'(credit), 32'd1);
        repeat (4) step(1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        check_eq("midrel_ovr", 32'(ovr_cnt), 32'd3);
        check_eq("midrel_credit_end", 32'(credit), 32'd0);
        check_eq("midrel_fills", 32'(n_fill), 32'd20);
        check_eq("midrel_skips", 32'(n_skip), 32'd12);

        // Release and consume together, then saturation
        step(1'b0, 1'b1, 1);
        repeat (3) step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 2);
        check_eq("relcons_credit", 32'(credit), 32'd2);
        step(1'b0, 1'b1, 10);
        check_eq("sat_credit", 32'(credit), 32'd4);
        check_eq("model_credit", 32'(credit), 32'(m_credit));

        // Graceful stop after two fills of a buffer
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        stop_req = 1'b1;
        #1;
        check_eq("stop_ready", 32'(brst_req_ready), 32'd0);
        push_exp(1'b0, m_wr, 2);
        push_exp(1'b0, m_wr, 3);
        @(posedge clk);
        #1;
        check_eq("flush1_done", 32'(stop_done), 32'd0);
        @(posedge clk);
        #1;
        check_eq("flush2_done", 32'(stop_done), 32'd0);
        @(posedge clk);
        #1;
        check_eq("stop_done", 32'(stop_done), 32'd1);
        check_eq("flush_credit", 32'(credit), 32'd3);
        stop_req = 1'b0;
        dma_en   = 1'b0;
        @(posedge clk);
        #1;
        check_eq("idle_done", 32'(stop_done), 32'd0);

        // Abort mid-flush, then restart
        dma_en = 1'b1;
        @(posedge clk);
        #1;
        model_start(3, 3);
        check_eq("restart_credit", 32'(credit), 32'd4);
        repeat (6) step(1'b1, 1'b0, 0);
        stop_req = 1'b1;
        push_exp(1'b0, m_wr, 2);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        dma_en   = 1'b0;
        stop_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort_ready", 32'(brst_req_ready), 32'd0);
        check_eq("abort_done", 32'(stop_done), 32'd0);
        check_eq("abort_credit", 32'(credit), 32'd3);
        dma_en = 1'b1;
        @(posedge clk);
        #1;
        model_start(3, 3);
        check_eq("reen_credit", 32'(credit), 32'd4);
        check_eq("reen_ready", 32'(brst_req_ready), 32'd1);
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
